// File: rtl/fft16_ofdm_core.sv
// 16-point radix-2 DIT FFT for the OFDM demonstrator: one frame every 5 clocks.
// Eight shared butterfly lanes are re-pointed at each stage's element pairs by the FSM.
module fft16_bfly #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic signed [N-1:0] a_re_i,
  input  logic signed [N-1:0] a_im_i,
  input  logic signed [N-1:0] b_re_i,
  input  logic signed [N-1:0] b_im_i,
  input  logic signed [N-1:0] w_re_i,
  input  logic signed [N-1:0] w_im_i,
  output logic signed [N-1:0] ya_re_o,
  output logic signed [N-1:0] ya_im_o,
  output logic signed [N-1:0] yb_re_o,
  output logic signed [N-1:0] yb_im_o
);
  logic signed [2*N-1:0] p_re, p_im;
  logic signed [N-1:0]   t_re, t_im;

  // Full-width products; the arithmetic shift floors, then the low N bits are kept.
  assign p_re = (w_re_i * b_re_i) - (w_im_i * b_im_i);
  assign p_im = (w_re_i * b_im_i) + (w_im_i * b_re_i);
  assign t_re = N'(p_re >>> Q);
  assign t_im = N'(p_im >>> Q);

  assign ya_re_o = a_re_i + t_re;
  assign ya_im_o = a_im_i + t_im;
  assign yb_re_o = a_re_i - t_re;
  assign yb_im_o = a_im_i - t_im;
endmodule

module fft16_ofdm_core #(
  parameter int N      = 16,
  parameter int Q      = 8,
  parameter int STAGES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] in_1Hz_re, in_1Hz_im,
  input  logic [N-1:0] in_2Hz_re, in_2Hz_im,
  input  logic [N-1:0] in_4Hz_re, in_4Hz_im,
  input  logic [N-1:0] in_8Hz_re, in_8Hz_im,
  output logic [N-1:0] out0_re,  out0_im,
  output logic [N-1:0] out1_re,  out1_im,
  output logic [N-1:0] out2_re,  out2_im,
  output logic [N-1:0] out3_re,  out3_im,
  output logic [N-1:0] out4_re,  out4_im,
  output logic [N-1:0] out5_re,  out5_im,
  output logic [N-1:0] out6_re,  out6_im,
  output logic [N-1:0] out7_re,  out7_im,
  output logic [N-1:0] out8_re,  out8_im,
  output logic [N-1:0] out9_re,  out9_im,
  output logic [N-1:0] out10_re, out10_im,
  output logic [N-1:0] out11_re, out11_im,
  output logic [N-1:0] out12_re, out12_im,
  output logic [N-1:0] out13_re, out13_im,
  output logic [N-1:0] out14_re, out14_im,
  output logic [N-1:0] out15_re, out15_im,
  output logic         o_FFT_cycle_done
);
  localparam int PTS       = 1 << STAGES;
  localparam int NUM_LANES = PTS / 2;

  typedef enum logic [2:0] {LOAD, S1, S2, S3, S4} state_t;
  state_t state_q;

  logic [PTS-1:0][N-1:0]       dre_q, dim_q, dre_d, dim_d, ore_q, oim_q;
  logic [NUM_LANES-1:0][N-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic [NUM_LANES-1:0][N-1:0] ya_re, ya_im, yb_re, yb_im;
  logic                        done_q;
  int                          stg;

  function automatic logic [STAGES-1:0] bf_idx(input int lane, input int s, input bit hi);
    int h;
    h = 1 << s;
    return STAGES'(((lane >> s) << (s + 1)) + (lane & (h - 1)) + (hi ? h : 0));
  endfunction

  function automatic logic [2*N-1:0] tw_rom(input int lane, input int s);
    logic [STAGES-2:0] t;
    t = (STAGES-1)'((lane & ((1 << s) - 1)) << (STAGES - 1 - s));
    case (t)
      3'd0:    tw_rom = {N'(256),  N'(0)};
      3'd1:    tw_rom = {N'(237),  N'(-98)};
      3'd2:    tw_rom = {N'(181),  N'(-181)};
      3'd3:    tw_rom = {N'(98),   N'(-237)};
      3'd4:    tw_rom = {N'(0),    N'(-256)};
      3'd5:    tw_rom = {N'(-98),  N'(-237)};
      3'd6:    tw_rom = {N'(-181), N'(-181)};
      default: tw_rom = {N'(-237), N'(-98)};
    endcase
  endfunction

  always_comb begin
    case (state_q)
      S2:      stg = 1;
      S3:      stg = 2;
      S4:      stg = 3;
      default: stg = 0;
    endcase
  end

  always_comb begin
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      a_re[l] = dre_q[bf_idx(l, stg, 1'b0)];
      a_im[l] = dim_q[bf_idx(l, stg, 1'b0)];
      b_re[l] = dre_q[bf_idx(l, stg, 1'b1)];
      b_im[l] = dim_q[bf_idx(l, stg, 1'b1)];
      {w_re[l], w_im[l]} = tw_rom(l, stg);
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fft16_bfly #(.N(N), .Q(Q)) u_bfly (
      .a_re_i(a_re[l]), .a_im_i(a_im[l]), .b_re_i(b_re[l]), .b_im_i(b_im[l]),
      .w_re_i(w_re[l]), .w_im_i(w_im[l]),
      .ya_re_o(ya_re[l]), .ya_im_o(ya_im[l]), .yb_re_o(yb_re[l]), .yb_im_o(yb_im[l])
    );
  end

  // LOAD stores the frame bit-reversed so stage 4 lands in natural order.
  always_comb begin
    dre_d = dre_q;
    dim_d = dim_q;
    if (state_q == LOAD) begin
      dre_d = '0;
      dim_d = '0;
      dre_d[8] = in_1Hz_re; dim_d[8] = in_1Hz_im;
      dre_d[4] = in_2Hz_re; dim_d[4] = in_2Hz_im;
      dre_d[2] = in_4Hz_re; dim_d[2] = in_4Hz_im;
      dre_d[1] = in_8Hz_re; dim_d[1] = in_8Hz_im;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        dre_d[bf_idx(l, stg, 1'b0)] = ya_re[l];
        dim_d[bf_idx(l, stg, 1'b0)] = ya_im[l];
        dre_d[bf_idx(l, stg, 1'b1)] = yb_re[l];
        dim_d[bf_idx(l, stg, 1'b1)] = yb_im[l];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= LOAD;
      dre_q   <= '0;
      dim_q   <= '0;
      ore_q   <= '0;
      oim_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      dre_q  <= dre_d;
      dim_q  <= dim_d;
      done_q <= 1'b0;
      case (state_q)
        LOAD: state_q <= S1;
        S1:   state_q <= S2;
        S2:   state_q <= S3;
        S3:   state_q <= S4;
        S4: begin
          state_q <= LOAD;
          ore_q   <= dre_d;
          oim_q   <= dim_d;
          done_q  <= 1'b1;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign o_FFT_cycle_done = done_q;
  assign out0_re  = ore_q[0];  assign out0_im  = oim_q[0];
  assign out1_re  = ore_q[1];  assign out1_im  = oim_q[1];
  assign out2_re  = ore_q[2];  assign out2_im  = oim_q[2];
  assign out3_re  = ore_q[3];  assign out3_im  = oim_q[3];
  assign out4_re  = ore_q[4];  assign out4_im  = oim_q[4];
  assign out5_re  = ore_q[5];  assign out5_im  = oim_q[5];
  assign out6_re  = ore_q[6];  assign out6_im  = oim_q[6];
  assign out7_re  = ore_q[7];  assign out7_im  = oim_q[7];
  assign out8_re  = ore_q[8];  assign out8_im  = oim_q[8];
  assign out9_re  = ore_q[9];  assign out9_im  = oim_q[9];
  assign out10_re = ore_q[10]; assign out10_im = oim_q[10];
  assign out11_re = ore_q[11]; assign out11_im = oim_q[11];
  assign out12_re = ore_q[12]; assign out12_im = oim_q[12];
  assign out13_re = ore_q[13]; assign out13_im = oim_q[13];
  assign out14_re = ore_q[14]; assign out14_im = oim_q[14];
  assign out15_re = ore_q[15]; assign out15_im = oim_q[15];
endmodule

// File: tb/tb_fft16_ofdm_core.sv
// Scoreboard bench for fft16_ofdm_core: expected frames queued at LOAD, checked at done.
module tb_fft16_ofdm_core;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] i1r, i1i, i2r, i2i, i4r, i4i, i8r, i8i;
  logic [15:0][N-1:0] ore, oim;
  logic done;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0][N-1:0] re;
    logic [15:0][N-1:0] im;
    logic [15:0]        chk;
    logic [1:0]         tol;
  } exp_t;
  exp_t sb[$];

  int rom_re[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int rom_im[8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  always #5 clk = ~clk;

  fft16_ofdm_core dut (
    .i_clk(clk), .i_rst(rst_n),
    .in_1Hz_re(i1r), .in_1Hz_im(i1i), .in_2Hz_re(i2r), .in_2Hz_im(i2i),
    .in_4Hz_re(i4r), .in_4Hz_im(i4i), .in_8Hz_re(i8r), .in_8Hz_im(i8i),
    .out0_re(ore[0]),   .out0_im(oim[0]),   .out1_re(ore[1]),   .out1_im(oim[1]),
    .out2_re(ore[2]),   .out2_im(oim[2]),   .out3_re(ore[3]),   .out3_im(oim[3]),
    .out4_re(ore[4]),   .out4_im(oim[4]),   .out5_re(ore[5]),   .out5_im(oim[5]),
    .out6_re(ore[6]),   .out6_im(oim[6]),   .out7_re(ore[7]),   .out7_im(oim[7]),
    .out8_re(ore[8]),   .out8_im(oim[8]),   .out9_re(ore[9]),   .out9_im(oim[9]),
    .out10_re(ore[10]), .out10_im(oim[10]), .out11_re(ore[11]), .out11_im(oim[11]),
    .out12_re(ore[12]), .out12_im(oim[12]), .out13_re(ore[13]), .out13_im(oim[13]),
    .out14_re(ore[14]), .out14_im(oim[14]), .out15_re(ore[15]), .out15_im(oim[15]),
    .o_FFT_cycle_done(done)
  );

  function automatic int tw_re(input int i);
    return (i < 8) ? rom_re[i] : -rom_re[i-8];
  endfunction
  function automatic int tw_im(input int i);
    return (i < 8) ? rom_im[i] : -rom_im[i-8];
  endfunction

  // A lone 256-amplitude symbol at element m gives X[k] = 256*W16^(m*k).
  function automatic exp_t tone_exp(input int m);
    exp_t e;
    e = '0;
    e.chk = '1;
    e.tol = 2'd1;
    for (int k = 0; k < 16; k++) begin
      e.re[k] = N'(tw_re((m * k) % 16));
      e.im[k] = N'(tw_im((m * k) % 16));
    end
    return e;
  endfunction

  function automatic exp_t ofdm_exp();
    exp_t e;
    e = '0;
    e.chk = 16'h1111;
    e.re[4]  = 16'h0233; e.im[4]  = 16'hFC3B;
    e.re[8]  = 16'hFD2C; e.im[8]  = 16'hFE6E;
    e.re[12] = 16'h00A1; e.im[12] = 16'hFF0F;
    return e;
  endfunction

  task automatic set_in(input logic [N-1:0] a, b, c, d, e, f, g, h);
    i1r = a; i1i = b; i2r = c; i2i = d; i4r = e; i4i = f; i8r = g; i8i = h;
  endtask

  task automatic set_ofdm;
    set_in(16'h016A, 16'h00C9, 16'hFE96, 16'h00C9, 16'h016A, 16'hFF37, 16'hFE96, 16'hFF37);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_in('0, '0, '0, '0, '0, '0, '0, '0);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({ore, oim} !== '0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold: outs_nonzero=%0b done=%b want outs 0 done 0", |{ore, oim}, done);
      end
    end
  endtask

  task automatic test_cadence;
    int first;
    first = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 12 && first == 0; i++) begin
      @(negedge clk);
      if (done) first = i;
    end
    n_cmp++;
    if (first != 5) begin
      n_bad++;
      $display("FAIL first_done: edge %0d want 5", first);
    end
    for (int p = 0; p < 3; p++)
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        n_cmp++;
        if (done !== (c == 5)) begin
          n_bad++;
          $display("FAIL cadence p%0d c%0d: done=%b want %b", p, c, done, (c == 5));
        end
      end
  endtask

  task automatic test_ofdm;
    bit ok;
    exp_t e;
    wait_done(ok);
    set_ofdm();
    sb.push_back(ofdm_exp());
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ofdm_timeout: no done want done"); end
    e = sb.pop_front();
    for (int k = 0; k < 16; k++) if (e.chk[k]) begin
      n_cmp++;
      if ({ore[k], oim[k]} !== {e.re[k], e.im[k]}) begin
        n_bad++;
        $display("FAIL ofdm bin%0d: got (%h,%h) want (%h,%h)", k, ore[k], oim[k], e.re[k], e.im[k]);
      end
    end
  endtask

  task automatic test_tone;
    bit ok;
    exp_t e;
    int dr, di;
    wait_done(ok);
    set_in(16'h0100, '0, '0, '0, '0, '0, '0, '0);
    sb.push_back(tone_exp(1));
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tone_timeout: no done want done"); end
    e = sb.pop_front();
    for (int k = 0; k < 16; k++) begin
      dr = int'(signed'(ore[k])) - int'(signed'(e.re[k]));
      di = int'(signed'(oim[k])) - int'(signed'(e.im[k]));
      n_cmp++;
      if (dr > int'(e.tol) || dr < -int'(e.tol) || di > int'(e.tol) || di < -int'(e.tol)) begin
        n_bad++;
        $display("FAIL tone bin%0d: got (%h,%h) want (%h,%h)+-%0d", k, ore[k], oim[k], e.re[k], e.im[k], e.tol);
      end
    end
  endtask

  task automatic test_midframe;
    bit ok;
    exp_t e;
    int dr, di;
    wait_done(ok);
    set_in(16'h0100, '0, '0, '0, '0, '0, '0, '0);
    sb.push_back(tone_exp(1));
    @(negedge clk);
    @(negedge clk);
    set_in('0, '0, 16'h0100, '0, '0, '0, '0, '0);
    sb.push_back(tone_exp(2));
    for (int f = 0; f < 2; f++) begin
      wait_done(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL mid_timeout f%0d: no done want done", f); end
      e = sb.pop_front();
      for (int k = 0; k < 16; k++) begin
        dr = int'(signed'(ore[k])) - int'(signed'(e.re[k]));
        di = int'(signed'(oim[k])) - int'(signed'(e.im[k]));
        n_cmp++;
        if (dr > int'(e.tol) || dr < -int'(e.tol) || di > int'(e.tol) || di < -int'(e.tol)) begin
          n_bad++;
          $display("FAIL midframe f%0d bin%0d: got (%h,%h) want (%h,%h)", f, k, ore[k], oim[k], e.re[k], e.im[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    exp_t e;
    int first;
    wait_done(ok);
    set_ofdm();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ore, oim} !== '0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_clear: outs_nonzero=%0b done=%b want 0", |{ore, oim}, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(ofdm_exp());
    first = 0;
    for (int i = 1; i <= 12 && first == 0; i++) begin
      @(negedge clk);
      if (done) first = i;
    end
    n_cmp++;
    if (first != 5) begin n_bad++; $display("FAIL rst_mid_restart: edge %0d want 5", first); end
    e = sb.pop_front();
    for (int k = 0; k < 16; k++) if (e.chk[k]) begin
      n_cmp++;
      if ({ore[k], oim[k]} !== {e.re[k], e.im[k]}) begin
        n_bad++;
        $display("FAIL rst_mid bin%0d: got (%h,%h) want (%h,%h)", k, ore[k], oim[k], e.re[k], e.im[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_ofdm();
    test_tone();
    test_midframe();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fft16_ofdm_core.md
Name: fft16_ofdm_core

Overview:
- 16-point radix-2 decimation-in-time FFT for an OFDM demonstrator.
- Four complex subcarrier symbols are placed in bins 1, 2, 4 and 8 of a 16-element frame; all other elements are zero.
- The frame is transformed over STAGES clocked butterfly stages, and all 16 complex bins are presented in parallel with a one-cycle done pulse.
- Sits between the symbol mapper and downstream OFDM inspection logic.

Parameters:
- N, 16: sample word width, signed two's complement, for real and imaginary parts.
- Q, 8: number of fractional bits (Q-format); twiddles use the same format.
- STAGES, 4: butterfly stages, equal to log2(16).

Ports:
- i_clk  input  1  single system clock, rising-edge.
- i_rst  input  1  asynchronous, active-low reset.
- in_1Hz_re, in_1Hz_im  input  N each  symbol for frame element 1.
- in_2Hz_re, in_2Hz_im  input  N each  symbol for frame element 2.
- in_4Hz_re, in_4Hz_im  input  N each  symbol for frame element 4.
- in_8Hz_re, in_8Hz_im  input  N each  symbol for frame element 8.
- outK_re, outK_im (K=0..15)  output  N each  FFT bin K, registered.
- o_FFT_cycle_done  output  1  one-cycle pulse when the outputs update.

Behaviour:
- Reset: i_rst low asynchronously clears all of the following:
  - all outK_re/outK_im to 0;
  - o_FFT_cycle_done to 0;
  - all internal stage registers to 0;
  - the FSM to LOAD.
- Reset mid-frame discards the frame. After release, the first LOAD happens on the next rising edge.
- FSM states and transitions: LOAD -> S1 -> S2 -> S3 -> S4 -> LOAD, one state per clock, free-running. There is no input handshake.
- LOAD:
  - Samples the eight input words into frame x[0..15], with x[1]=in_1Hz, x[2]=in_2Hz, x[4]=in_4Hz, x[8]=in_8Hz, and all other elements = 0.
  - Frame is stored in bit-reversed order for DIT.
- Sk (k=1..4):
  - Performs all 8 butterflies of stage k, using span 2^(k-1) and twiddle W16^(m*16/2^k), with W16 = exp(-j*2*pi/16).
  - Butterfly: A' = A + W*B, B' = A - W*B.
- S4 completion:
  - The stage-4 result is written to outK in natural order on the same edge that leaves S4.
  - o_FFT_cycle_done is high for exactly the one cycle following that edge.
- Timing: period 5 clocks. Latency from the LOAD sampling edge to the outputs valid is 5 edges. Outputs hold their value between updates.
- Input changes outside the LOAD edge have no effect on the frame in flight.
- Twiddle ROM values in Q8 (cos, -sin):
  - W0 = (256, 0)
  - W1 = (237, -98)
  - W2 = (181, -181)
  - W3 = (98, -237)
  - W4 = (0, -256)
  - W5 = (-98, -237)
  - W6 = (-181, -181)
  - W7 = (-237, -98)
- Arithmetic:
  - Complex multiply uses 2N-bit signed products; each real/imag sum of products is arithmetic-shifted right by Q, which truncates toward minus infinity, then keeps the low N bits.
  - Adds and subtracts are N-bit with wrap-around. There is no saturation and no per-stage scaling.
  - Multiplies by W0 and W4 are exact.
- Required result: X[k] = sum over n of x[n]*W16^(nk), within fixed-point truncation error.

Test Plan:
- Reset: hold i_rst low for 3 cycles -> all outputs 0 and o_FFT_cycle_done 0; outputs stay 0 while reset is held.
- Done cadence: release reset and count cycles -> done pulses one cycle wide, exactly every 5 clocks; the first pulse comes 5 edges after the first LOAD.
- OFDM frame input:
  - Inputs: in_1Hz = (0x016A, 0x00C9), in_2Hz = (0xFE96, 0x00C9), in_4Hz = (0x016A, 0xFF37), in_8Hz = (0xFE96, 0xFF37).
  - Required outputs after done:
    - out0 = (0x0000, 0x0000)
    - out4 = (0x0233, 0xFC3B)
    - out8 = (0xFD2C, 0xFE6E)
    - out12 = (0x00A1, 0xFF0F)
- Single tone: in_1Hz = (0x0100, 0), others 0 -> outK ≈ (256*cos(2πK/16), -256*sin(2πK/16)) within ±1 LSB, e.g. out0 = (0x0100, 0) and out4 = (0, 0xFF00).
- Mid-frame input change: change the inputs during S2 -> the current frame's outputs match the old inputs; the new values appear one period later.
- Reset mid-frame: assert i_rst during S3 -> outputs clear immediately; after release the FSM restarts at LOAD and produces a full result 5 edges later.
